// File: rtl/axi_master_pkg.sv
// Shared types and constants for the AXI4 master port.
// Bus widths match the interconnect's AXI_define.svh widths.
package axi_master_pkg;

  localparam int AXI_ID_BITS    = 4;
  localparam int AXI_ADDR_BITS  = 32;
  localparam int AXI_LEN_BITS   = 8;
  localparam int AXI_SIZE_BITS  = 3;
  localparam int AXI_BURST_BITS = 2;
  localparam int AXI_DATA_BITS  = 32;
  localparam int AXI_STRB_BITS  = 4;
  localparam int AXI_RESP_BITS  = 2;

  localparam logic [AXI_BURST_BITS-1:0] BURST_INCR = 2'b01;
  localparam logic [AXI_SIZE_BITS-1:0]  SIZE_WORD  = 3'b010;
  localparam logic [AXI_RESP_BITS-1:0]  RESP_OKAY  = 2'b00;

  typedef logic [AXI_LEN_BITS-1:0] len_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WADDR,
    S_WRESP
  } state_e;

  typedef struct packed {
    logic [AXI_ADDR_BITS-1:0] addr;
    len_t                     len;
    logic [AXI_DATA_BITS-1:0] wdata;
    logic [AXI_STRB_BITS-1:0] wstrb;
    logic                     write;
  } req_t;

  function automatic len_t clamp_len(
    input len_t len,
    input len_t max_len
  );
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/axi_master_if.sv
// AXI4 channel bundle seen from one master port.
// RID/BID are not carried: one outstanding transaction needs no ID match.
interface axi_master_if;
  import axi_master_pkg::*;

  logic [AXI_ID_BITS-1:0]    ARID;
  logic [AXI_ADDR_BITS-1:0]  ARADDR;
  logic [AXI_LEN_BITS-1:0]   ARLEN;
  logic [AXI_SIZE_BITS-1:0]  ARSIZE;
  logic [AXI_BURST_BITS-1:0] ARBURST;
  logic                      ARVALID;
  logic                      ARREADY;

  logic [AXI_DATA_BITS-1:0]  RDATA;
  logic [AXI_RESP_BITS-1:0]  RRESP;
  logic                      RLAST;
  logic                      RVALID;
  logic                      RREADY;

  logic [AXI_ID_BITS-1:0]    AWID;
  logic [AXI_ADDR_BITS-1:0]  AWADDR;
  logic [AXI_LEN_BITS-1:0]   AWLEN;
  logic [AXI_SIZE_BITS-1:0]  AWSIZE;
  logic [AXI_BURST_BITS-1:0] AWBURST;
  logic                      AWVALID;
  logic                      AWREADY;

  logic [AXI_DATA_BITS-1:0]  WDATA;
  logic [AXI_STRB_BITS-1:0]  WSTRB;
  logic                      WLAST;
  logic                      WVALID;
  logic                      WREADY;

  logic [AXI_RESP_BITS-1:0]  BRESP;
  logic                      BVALID;
  logic                      BREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RDATA, RRESP, RLAST, RVALID,
    output RREADY,
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BRESP, BVALID,
    output BREADY
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RDATA, RRESP, RLAST, RVALID,
    input  RREADY,
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BRESP, BVALID,
    input  BREADY
  );

endinterface

// File: rtl/axi_master_port.sv
// CPU/cache request to AXI4 initiator: INCR read bursts,
// single-beat writes with AW and W launched together.
module axi_master_port
  import axi_master_pkg::*;
#(
  parameter logic [AXI_ID_BITS-1:0] MASTER_ID = '0,
  parameter int                     MAX_LEN   = 3
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [AXI_ADDR_BITS-1:0] req_addr,
  input  logic [AXI_LEN_BITS-1:0]  req_len,
  input  logic [AXI_DATA_BITS-1:0] req_wdata,
  input  logic [AXI_STRB_BITS-1:0] req_wstrb,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [AXI_DATA_BITS-1:0] rsp_rdata,
  output logic                     rsp_last,
  output logic                     rsp_err,
  axi_master_if.master             axi
);

  localparam len_t MAX_LEN_L = len_t'(MAX_LEN);

  state_e state_q, state_d;
  req_t   req_q, req_d;
  len_t   cnt_q, cnt_d;
  logic   aw_sent_q, aw_sent_d;
  logic   w_sent_q, w_sent_d;
  logic   aw_done, w_done;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      cnt_q     <= '0;
      aw_sent_q <= 1'b0;
      w_sent_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      cnt_q     <= cnt_d;
      aw_sent_q <= aw_sent_d;
      w_sent_q  <= w_sent_d;
    end
  end

  // Payloads come straight from the latched request, so they stay
  // stable for as long as any VALID is held.
  assign axi.ARID    = MASTER_ID;
  assign axi.ARADDR  = req_q.addr;
  assign axi.ARLEN   = req_q.len;
  assign axi.ARSIZE  = SIZE_WORD;
  assign axi.ARBURST = BURST_INCR;
  assign axi.AWID    = MASTER_ID;
  assign axi.AWADDR  = req_q.addr;
  assign axi.AWLEN   = '0;
  assign axi.AWSIZE  = SIZE_WORD;
  assign axi.AWBURST = BURST_INCR;
  assign axi.WDATA   = req_q.wdata;
  assign axi.WSTRB   = req_q.wstrb;
  assign axi.WLAST   = 1'b1;
  assign rsp_rdata   = axi.RDATA;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    aw_sent_d   = aw_sent_q;
    w_sent_d    = w_sent_q;
    aw_done     = 1'b0;
    w_done      = 1'b0;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_last    = 1'b0;
    rsp_err     = 1'b0;
    axi.ARVALID = 1'b0;
    axi.RREADY  = 1'b0;
    axi.AWVALID = 1'b0;
    axi.WVALID  = 1'b0;
    axi.BREADY  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          req_d.addr  = req_addr;
          req_d.len   = req_write ? '0 : clamp_len(req_len, MAX_LEN_L);
          req_d.wdata = req_wdata;
          req_d.wstrb = req_wstrb;
          req_d.write = req_write;
          aw_sent_d   = 1'b0;
          w_sent_d    = 1'b0;
          state_d     = req_write ? S_WADDR : S_RADDR;
        end
      end
      S_RADDR: begin
        axi.ARVALID = 1'b1;
        if (axi.ARREADY) begin
          cnt_d   = '0;
          state_d = S_RDATA;
        end
      end
      S_RDATA: begin
        axi.RREADY = rsp_ready;
        rsp_valid  = axi.RVALID;
        rsp_last   = axi.RLAST;
        rsp_err    = axi.RVALID &
                     ((axi.RRESP != RESP_OKAY) |
                      (axi.RLAST != (cnt_q == req_q.len)));
        if (axi.RVALID && rsp_ready) begin
          // Saturate so a slave that never sends RLAST cannot wrap us.
          if (cnt_q != '1)
            cnt_d = cnt_q + len_t'(1);
          if (axi.RLAST)
            state_d = S_IDLE;
        end
      end
      S_WADDR: begin
        axi.AWVALID = ~aw_sent_q;
        axi.WVALID  = ~w_sent_q;
        aw_done     = aw_sent_q | axi.AWREADY;
        w_done      = w_sent_q | axi.WREADY;
        aw_sent_d   = aw_done;
        w_sent_d    = w_done;
        if (aw_done && w_done)
          state_d = S_WRESP;
      end
      S_WRESP: begin
        axi.BREADY = rsp_ready;
        rsp_valid  = axi.BVALID;
        rsp_last   = 1'b1;
        rsp_err    = axi.BVALID & (axi.BRESP != RESP_OKAY);
        if (axi.BVALID && rsp_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
